stream_ram_server: RTL and testbench

//  Responder end of the stb/ack memory-command streams our test drivers emit (address, we, data_in out; data_out in).

---
 rtl/stream_ram_pkg.sv | 39 +++
 rtl/stream_ram_core.sv | 41 ++++
 rtl/stream_ram_server.sv | 174 +++++++++++++++++
 tb/tb_stream_ram_server.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_ram_pkg
//  Description : Shared FSM state encodings and the index-width helper
//                for the stream RAM server and its RAM core.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_ram_pkg;

    localparam logic [2:0] C_ST_GET_ADDR = 3'd0;
    localparam logic [2:0] C_ST_GET_WE   = 3'd1;
    localparam logic [2:0] C_ST_GET_DATA = 3'd2;
    localparam logic [2:0] C_ST_ACCESS   = 3'd3;
    localparam logic [2:0] C_ST_PUT_DATA = 3'd4;

    typedef enum logic [2:0] {
        ST_GET_ADDR = C_ST_GET_ADDR,
        ST_GET_WE   = C_ST_GET_WE,
        ST_GET_DATA = C_ST_GET_DATA,
        ST_ACCESS   = C_ST_ACCESS,
        ST_PUT_DATA = C_ST_PUT_DATA
    } state_t;

    // Ceiling log2, never less than 1 so a depth-1 RAM still gets a real
    // (single-bit) index port.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_ram_core.sv
`default_nettype none
// ============================================================================
//  Module      : stream_ram_core
//  Description : Single-port synchronous RAM, read-first. When en is high
//                the word at addr is registered onto dout and, if we is also
//                high, din is written to the same location on that edge.
//                dout holds its value while en is low. No reset on contents.
//  Revision    : 1.0 - initial release
//  Ports       : clk  - rising-edge clock
//                en   - access enable
//                we   - write enable (qualified by en)
//                addr - word index
//                din  - write data
//                dout - registered read data (pre-write word)
// ============================================================================
module stream_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= r_mem[addr];
            if (we) begin
                r_mem[addr] <= din;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_ram_server.sv
`default_nettype none
// ============================================================================
//  Module      : stream_ram_server
//  Description : Responder for the address / we / data_in stb-ack command
//                streams. Collects one field per stream in strict order,
//                performs a read-first RAM access and returns the pre-write
//                word on the output_data_out stream.
//  Revision    : 1.0 - initial release
//  Macro       : STREAM_RAM_BOUNDS_CHECK_EN - when defined, any depth >= 1
//                is allowed; addresses >= DEPTH suppress the write, return 0
//                and set the sticky error flag. When undefined, the address
//                wraps modulo DEPTH, error is tied 0 and DEPTH must be a
//                power of two.
//  Ports       : clk, rst (async, active-high)
//                input_address[_stb/_ack]   word address stream
//                input_we[_stb/_ack]        write-enable stream (bit 0 used)
//                input_data_in[_stb/_ack]   write-data stream
//                output_data_out[_stb/_ack] response stream (old word)
//                error                      sticky out-of-range flag
// ============================================================================
module stream_ram_server
    import stream_ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] input_address,
    input  logic                     input_address_stb,
    output logic                     input_address_ack,
    input  logic [31:0]              input_we,
    input  logic                     input_we_stb,
    output logic                     input_we_ack,
    input  logic [DATA_WIDTH-1:0]    input_data_in,
    input  logic                     input_data_in_stb,
    output logic                     input_data_in_ack,
    output logic [DATA_WIDTH-1:0]    output_data_out,
    output logic                     output_data_out_stb,
    input  logic                     output_data_out_ack,
    output logic                     error
);

    localparam int C_IDX_W = clog2(DEPTH);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic                     r_we;
    logic [DATA_WIDTH-1:0]    r_data_in;
    logic                     w_oob;
    logic                     w_ram_en;
    logic                     w_ram_we;
    logic [DATA_WIDTH-1:0]    w_ram_dout;
    logic                     w_unused_bits;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_GET_ADDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs. Each ack depends only on the
    // state, so an early stb on a later stream is simply left waiting.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next        = r_state;
        input_address_ack   = 1'b0;
        input_we_ack        = 1'b0;
        input_data_in_ack   = 1'b0;
        output_data_out_stb = 1'b0;
        case (r_state)
            ST_GET_ADDR: begin
                input_address_ack = !rst;
                if (input_address_stb) w_state_next = ST_GET_WE;
            end
            ST_GET_WE: begin
                input_we_ack = !rst;
                if (input_we_stb) w_state_next = ST_GET_DATA;
            end
            ST_GET_DATA: begin
                input_data_in_ack = !rst;
                if (input_data_in_stb) w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_state_next = ST_PUT_DATA;
            end
            ST_PUT_DATA: begin
                output_data_out_stb = !rst;
                if (output_data_out_ack) w_state_next = ST_GET_ADDR;
            end
            default: begin
                w_state_next = ST_GET_ADDR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Field latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_address <= '0;
            r_we      <= 1'b0;
            r_data_in <= '0;
        end else begin
            if (input_address_stb && input_address_ack) r_address <= input_address;
            if (input_we_stb && input_we_ack)           r_we      <= input_we[0];
            if (input_data_in_stb && input_data_in_ack) r_data_in <= input_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Range handling
    // ------------------------------------------------------------------
`ifdef STREAM_RAM_BOUNDS_CHECK_EN
    logic r_error;

    assign w_oob         = (r_address >= ADDRESS_WIDTH'(DEPTH));
    assign w_unused_bits = &{1'b0, input_we[31:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (r_state == ST_ACCESS && w_oob) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_pow2_check
        $error("stream_ram_server: DEPTH must be a power of two without STREAM_RAM_BOUNDS_CHECK_EN");
    end

    // Upper address bits are deliberately dropped: the index wraps.
    assign w_oob         = 1'b0;
    assign w_unused_bits = &{1'b0, input_we[31:1], r_address};
    assign error         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // RAM. Accessed for exactly the one ACCESS cycle; its registered dout
    // therefore stays stable for the whole PUT_DATA wait.
    // ------------------------------------------------------------------
    assign w_ram_en = (r_state == ST_ACCESS) && !w_oob;
    assign w_ram_we = w_ram_en && r_we;

    stream_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (C_IDX_W)
    ) u_core (
        .clk  (clk),
        .en   (w_ram_en),
        .we   (w_ram_we),
        .addr (r_address[C_IDX_W-1:0]),
        .din  (r_data_in),
        .dout (w_ram_dout)
    );

    // Masking with the stb keeps the output at 0 under reset and hides the
    // stale RAM register for out-of-range requests.
    assign output_data_out = (output_data_out_stb && !w_oob) ? w_ram_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_stream_ram_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_ram_server
//  Description : Self-checking bench for stream_ram_server. A plain array
//                model of the RAM supplies every expected response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_ram_server;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_address = '0;
    logic        input_address_stb = 1'b0;
    logic        input_address_ack;
    logic [31:0] input_we = '0;
    logic        input_we_stb = 1'b0;
    logic        input_we_ack;
    logic [31:0] input_data_in = '0;
    logic        input_data_in_stb = 1'b0;
    logic        input_data_in_ack;
    logic [31:0] output_data_out;
    logic        output_data_out_stb;
    logic        output_data_out_ack = 1'b0;
    logic        error;

    stream_ram_server dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_address       (input_address),
        .input_address_stb   (input_address_stb),
        .input_address_ack   (input_address_ack),
        .input_we            (input_we),
        .input_we_stb        (input_we_stb),
        .input_we_ack        (input_we_ack),
        .input_data_in       (input_data_in),
        .input_data_in_stb   (input_data_in_stb),
        .input_data_in_ack   (input_data_in_ack),
        .output_data_out     (output_data_out),
        .output_data_out_stb (output_data_out_stb),
        .output_data_out_ack (output_data_out_ack),
        .error               (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] model_mem [DEPTH];
    logic        model_err = 1'b0;

    // Reference: one whole transaction, returning the pre-write word.
    function automatic logic [31:0] model_txn(input logic [31:0] a, input logic w, input logic [31:0] d);
        logic [31:0] old;
        int idx;
`ifdef STREAM_RAM_BOUNDS_CHECK_EN
        if (a >= DEPTH) begin
            model_err = 1'b1;
            return 32'h0;
        end
        idx = int'(a);
`else
        idx = int'(a % DEPTH);
`endif
        old = model_mem[idx];
        if (w) model_mem[idx] = d;
        return old;
    endfunction

    task automatic idle_random(input int maxn);
        repeat ($urandom_range(0, maxn)) @(negedge clk);
    endtask

    // Each xfer task starts and ends just after a falling edge.
    task automatic xfer_addr(input logic [31:0] a);
        int n = 0;
        input_address = a;
        input_address_stb = 1'b1;
        while (!input_address_ack && n < 50) begin @(negedge clk); n++; end
        n_cmp++;
        if (input_address_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_handshake: ack=%b after %0d cycles, required 1", input_address_ack, n);
        end
        @(negedge clk);
        input_address_stb = 1'b0;
    endtask

    task automatic xfer_we(input logic w);
        int n = 0;
        logic [31:0] word;
        word = $urandom;
        word[0] = w;
        input_we = word;
        input_we_stb = 1'b1;
        while (!input_we_ack && n < 50) begin @(negedge clk); n++; end
        n_cmp++;
        if (input_we_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL we_handshake: ack=%b after %0d cycles, required 1", input_we_ack, n);
        end
        @(negedge clk);
        input_we_stb = 1'b0;
    endtask

    task automatic xfer_data(input logic [31:0] d);
        int n = 0;
        input_data_in = d;
        input_data_in_stb = 1'b1;
        while (!input_data_in_ack && n < 50) begin @(negedge clk); n++; end
        n_cmp++;
        if (input_data_in_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL data_handshake: ack=%b after %0d cycles, required 1", input_data_in_ack, n);
        end
        @(negedge clk);
        input_data_in_stb = 1'b0;
    endtask

    // Waits for the response, holds it off for 'hold' cycles, then consumes it.
    task automatic get_resp(input int hold, output logic [31:0] d);
        int n = 0;
        output_data_out_ack = 1'b0;
        while (!output_data_out_stb && n < 50) begin @(negedge clk); n++; end
        n_cmp++;
        if (output_data_out_stb !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_stb: stb=%b after %0d cycles, required 1", output_data_out_stb, n);
        end
        d = output_data_out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if (output_data_out_stb !== 1'b1 || output_data_out !== d ||
                {input_address_ack, input_we_ack, input_data_in_ack} !== 3'b000) begin
                n_fail++;
                $display("FAIL resp_hold: stb=%b data=%h acks=%b, required stb=1 data=%h acks=000",
                         output_data_out_stb, output_data_out,
                         {input_address_ack, input_we_ack, input_data_in_ack}, d);
            end
        end
        output_data_out_ack = 1'b1;
        @(negedge clk);
        output_data_out_ack = 1'b0;
        n_cmp++;
        if (input_address_ack !== 1'b1 || output_data_out_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_return: addr_ack=%b stb=%b, required addr_ack=1 stb=0",
                     input_address_ack, output_data_out_stb);
        end
    endtask

    task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input int hold, input int idle, input bit chk, input string name);
        logic [31:0] exp_v;
        logic [31:0] got;
        exp_v = model_txn(a, w, d);
        idle_random(idle);
        xfer_addr(a);
        idle_random(idle);
        xfer_we(w);
        idle_random(idle);
        xfer_data(d);
        get_resp(hold, got);
        if (chk) begin
            n_cmp++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL %s: data_out=%h, required %h (addr=%h we=%b)", name, got, exp_v, a, w);
            end
            n_cmp++;
            if (error !== model_err) begin
                n_fail++;
                $display("FAIL %s_error: error=%b, required %b", name, error, model_err);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        input_address_stb = 1'b1;
        input_data_in_stb = 1'b1;
        #1;
        n_cmp++;
        if ({input_address_ack, input_we_ack, input_data_in_ack, output_data_out_stb} !== 4'b0000 ||
            output_data_out !== 32'h0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: acks/stb=%b data=%h error=%b, required 0000 0 0",
                     {input_address_ack, input_we_ack, input_data_in_ack, output_data_out_stb},
                     output_data_out, error);
        end
        input_address_stb = 1'b0;
        input_data_in_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({input_address_ack, input_we_ack, input_data_in_ack, output_data_out_stb} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_release: acks/stb=%b, required 1000",
                     {input_address_ack, input_we_ack, input_data_in_ack, output_data_out_stb});
        end
        @(negedge clk);
    endtask

    // Fill the RAM with zeros so the model starts from a known image.
    task automatic test_preload();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = 32'h0;
            run_txn(i, 1'b1, 32'h0, 0, 0, 1'b0, "preload");
        end
    endtask

    task automatic test_throughput();
        logic [31:0] exp1, exp2, r2;
        int seen = 0;
        int t0 = 0;
        r2   = $urandom;
        exp1 = model_txn(32'd3, 1'b1, 32'hDEADBEEF);
        exp2 = model_txn(32'd3, 1'b0, r2);
        input_address = 32'd3;
        input_we = 32'h1;
        input_data_in = 32'hDEADBEEF;
        {input_address_stb, input_we_stb, input_data_in_stb, output_data_out_ack} = 4'b1111;
        for (int n = 0; n < 30 && seen < 2; n++) begin
            @(negedge clk);
            if (output_data_out_stb) begin
                n_cmp++;
                if (seen == 0) begin
                    if (output_data_out !== exp1) begin
                        n_fail++;
                        $display("FAIL tput_first: data_out=%h, required %h", output_data_out, exp1);
                    end
                    t0 = cyc;
                    input_we = 32'h0;
                    input_data_in = r2;
                end else begin
                    if (output_data_out !== exp2) begin
                        n_fail++;
                        $display("FAIL tput_second: data_out=%h, required %h", output_data_out, exp2);
                    end
                    n_cmp++;
                    if (cyc - t0 != 5) begin
                        n_fail++;
                        $display("FAIL tput_spacing: %0d cycles, required 5", cyc - t0);
                    end
                    {input_address_stb, input_we_stb, input_data_in_stb} = 3'b000;
                end
                seen++;
            end
        end
        n_cmp++;
        if (seen != 2) begin
            n_fail++;
            $display("FAIL tput_timeout: %0d responses, required 2", seen);
        end
        {input_address_stb, input_we_stb, input_data_in_stb} = 3'b000;
        @(negedge clk);
        output_data_out_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_first();
        run_txn(32'd7, 1'b1, 32'h11, 0, 1, 1'b1, "rf_write1");
        run_txn(32'd7, 1'b1, 32'h22, 0, 1, 1'b1, "rf_write2");
        run_txn(32'd7, 1'b0, $urandom, 0, 1, 1'b1, "rf_read");
    endtask

    task automatic test_wrap();
        run_txn(32'd259, 1'b1, 32'h55, 0, 0, 1'b1, "wrap_write");
        run_txn(32'd3, 1'b0, $urandom, 0, 0, 1'b1, "wrap_read");
    endtask

    task automatic test_backpressure();
        run_txn(32'd20, 1'b1, 32'hA5A5_0014, 0, 0, 1'b1, "bp_setup");
        run_txn(32'd20, 1'b0, $urandom, 10, 0, 1'b1, "bp_hold");
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_v;
        logic [31:0] got;
        run_txn(32'd9, 1'b1, 32'h0000_1234, 0, 0, 1'b1, "rmid_setup");
        xfer_addr(32'd9);
        xfer_we(1'b1);
        input_data_in = 32'h99;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({input_address_ack, input_we_ack, input_data_in_ack, output_data_out_stb} !== 4'b0000 ||
            output_data_out !== 32'h0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_outputs: acks/stb=%b data=%h error=%b, required 0000 0 0",
                     {input_address_ack, input_we_ack, input_data_in_ack, output_data_out_stb},
                     output_data_out, error);
        end
        model_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_v = model_txn(32'd9, 1'b0, 32'h0);
        xfer_addr(32'd9);
        xfer_we(1'b0);
        xfer_data(32'h0);
        get_resp(0, got);
        n_cmp++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_discard: data_out=%h, required %h", got, exp_v);
        end
    endtask

    task automatic test_early_stb();
        logic [31:0] exp_v;
        logic [31:0] got;
        input_data_in = 32'hAAAA_AAAA;
        input_data_in_stb = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (input_data_in_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL early_get_addr: data_ack=%b, required 0", input_data_in_ack);
        end
        xfer_addr(32'd13);
        n_cmp++;
        if (input_data_in_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL early_get_we: data_ack=%b, required 0", input_data_in_ack);
        end
        xfer_we(1'b1);
        exp_v = model_txn(32'd13, 1'b1, 32'hBBBB_BBBB);
        xfer_data(32'hBBBB_BBBB);
        get_resp(0, got);
        n_cmp++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL early_resp: data_out=%h, required %h", got, exp_v);
        end
        run_txn(32'd13, 1'b0, $urandom, 0, 0, 1'b1, "early_readback");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_txn($urandom_range(0, 300), 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 3), 2, 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_throughput();
        test_read_first();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_early_stb();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
